tx_cmd_dispatcher: RTL and testbench

TX_CMD_DISPATCHER -- requirements
Module: tx_cmd_dispatcher

---
 rtl/tx_cmd_pkg.sv | 29 ++
 rtl/tx_cmd_fifo.sv | 73 +++++++
 rtl/tx_cmd_dispatcher.sv | 159 +++++++++++++++
 tb/tb_tx_cmd_dispatcher.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_cmd_pkg.sv
// Shared types and constants for the TX command dispatcher.
//   state_t   : dispatcher FSM states
//   ADDR_W    : width of the send-engine RAM address
//   SLOT_W    : width of a PCIe slot index
//   slot_addr : base + (slot << shift), truncated to ADDR_W bits
package tx_cmd_pkg;

    localparam int ADDR_W = 25;
    localparam int SLOT_W = 6;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    // The sum is taken in ADDR_W bits so it wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] slot_addr(
        input logic [ADDR_W-1:0] base,
        input logic [SLOT_W-1:0] slot,
        input int                shift
    );
        logic [ADDR_W-1:0] offset;
        offset = ADDR_W'(slot) << shift;
        return base + offset;
    endfunction

endpackage

// File: rtl/tx_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO holding queued slot indices.
//   clk, rst   : clock and synchronous active-high reset
//   push       : write request; accepted when not full or when popping this cycle
//   push_data  : data written on an accepted push
//   pop        : remove the head entry (ignored when empty)
//   pop_data   : head entry, valid whenever empty is low
//   level      : number of stored entries
//   full/empty : occupancy flags
//   drop       : push requested but refused this cycle
module tx_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign do_pop   = pop && !empty;
    // When full, a same-cycle pop frees the slot the write lands in.
    assign do_push  = push && (!full || do_pop);
    assign drop     = push && !do_push;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/tx_cmd_dispatcher.sv
// Queues PCIe send requests and hands them one at a time to the send engine.
//   clock_clk, reset_reset : clock and synchronous active-high reset
//   pcie_start_ram_addr    : slot index, qualified by pcie_signal
//   pcie_signal            : one-cycle request strobe
//   send_start_ram_addr    : RAM address of the command being sent
//   send_cmd_send          : one-cycle send command
//   tx_done                : send-engine completion pulse
//   clear_flags            : clears overflow / timeout_err
//   busy                   : FSM not idle or requests queued
//   fifo_level             : queued request count
//   overflow, timeout_err  : sticky error flags
//   sent_count             : completed sends (wrapping)
//
// state     | meaning
// IDLE      | waiting for a queued request; pops and latches its address
// ISSUE     | send_cmd_send asserted for this one cycle
// WAIT_DONE | waiting for tx_done or the timeout to expire
// GAP       | enforced idle spacing before the next command
module tx_cmd_dispatcher
    import tx_cmd_pkg::*;
#(
    parameter int                FIFO_DEPTH     = 4,
    parameter int                SLOT_SHIFT     = 11,
    parameter logic [ADDR_W-1:0] RAM_BASE       = 25'h0,
    parameter int                TIMEOUT_CYCLES = 65535,
    parameter int                GAP_CYCLES     = 12
) (
    input  logic                          clock_clk,
    input  logic                          reset_reset,
    input  logic [SLOT_W-1:0]             pcie_start_ram_addr,
    input  logic                          pcie_signal,
    output logic [ADDR_W-1:0]             send_start_ram_addr,
    output logic                          send_cmd_send,
    input  logic                          tx_done,
    input  logic                          clear_flags,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          timeout_err,
    output logic [15:0]                   sent_count
);

    // Down-counter reload values; the terminal count of zero is the last cycle.
    // A zero-length gap still spends one cycle in GAP.
    localparam int TMO_LOAD = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int GAP_LOAD = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0;
    localparam int TMAX     = (TMO_LOAD > GAP_LOAD) ? TMO_LOAD : GAP_LOAD;
    localparam int TW       = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_nxt;
    logic              pop;
    logic              done_ok;
    logic              timed_out;
    logic [SLOT_W-1:0] head;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_drop;

    tx_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SLOT_W)
    ) u_fifo (
        .clk       (clock_clk),
        .rst       (reset_reset),
        .push      (pcie_signal),
        .push_data (pcie_start_ram_addr),
        .pop       (pop),
        .pop_data  (head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    always_ff @(posedge clock_clk) begin
        if (reset_reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        pop       = 1'b0;
        done_ok   = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_DONE;
                timer_nxt = TW'(TMO_LOAD);
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    done_ok   = 1'b1;
                    state_nxt = GAP;
                    timer_nxt = TW'(GAP_LOAD);
                end else if (timer == '0) begin
                    timed_out = 1'b1;
                    state_nxt = GAP;
                    timer_nxt = TW'(GAP_LOAD);
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            GAP: begin
                if (timer == '0) begin
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Set events take priority over clear_flags.
    always_ff @(posedge clock_clk) begin
        if (reset_reset) begin
            send_start_ram_addr <= '0;
            sent_count          <= '0;
            overflow            <= 1'b0;
            timeout_err         <= 1'b0;
        end else begin
            if (pop) begin
                send_start_ram_addr <= slot_addr(RAM_BASE, head, SLOT_SHIFT);
            end
            if (done_ok) begin
                sent_count <= sent_count + 16'd1;
            end
            if (fifo_drop) begin
                overflow <= 1'b1;
            end else if (clear_flags) begin
                overflow <= 1'b0;
            end
            if (timed_out) begin
                timeout_err <= 1'b1;
            end else if (clear_flags) begin
                timeout_err <= 1'b0;
            end
        end
    end

    assign send_cmd_send = (state == ISSUE);
    assign busy          = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_tx_cmd_dispatcher.sv
// Two dispatcher instances share one stimulus stream:
//   lane 0: RAM_BASE=0,         TIMEOUT=100, GAP=12
//   lane 1: RAM_BASE=25'h1FFF000, TIMEOUT=8, GAP=0
// Each lane has a timeline model (queue of slots plus the cycle numbers at
// which the dispatcher is next free / issues) compared every cycle.
module tb_tx_cmd_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig;
    logic        done;
    logic        clr;
    logic [5:0]  slot;

    logic [24:0] addr_o [2];
    logic        send_o [2];
    logic        busy_o [2];
    logic        ovf_o  [2];
    logic        to_o   [2];
    logic [2:0]  lvl_o  [2];
    logic [15:0] cnt_o  [2];

    int     errors = 0;
    int     checks = 0;
    longint cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int          GAPC = (g == 0) ? 12 : 0;
        localparam int          TMO  = (g == 0) ? 100 : 8;
        localparam logic [24:0] BASE = (g == 0) ? 25'h0 : 25'h1FFF000;
        localparam int          GEFF = (GAPC == 0) ? 1 : GAPC;

        tx_cmd_dispatcher #(
            .FIFO_DEPTH     (4),
            .SLOT_SHIFT     (11),
            .RAM_BASE       (BASE),
            .TIMEOUT_CYCLES (TMO),
            .GAP_CYCLES     (GAPC)
        ) dut (
            .clock_clk           (clk),
            .reset_reset         (rst),
            .pcie_start_ram_addr (slot),
            .pcie_signal         (sig),
            .send_start_ram_addr (addr_o[g]),
            .send_cmd_send       (send_o[g]),
            .tx_done             (done),
            .clear_flags         (clr),
            .busy                (busy_o[g]),
            .fifo_level          (lvl_o[g]),
            .overflow            (ovf_o[g]),
            .timeout_err         (to_o[g]),
            .sent_count          (cnt_o[g])
        );

        logic [5:0]  q [$];
        longint      mcyc      = 0;
        longint      ready_at  = 0;   // first cycle the dispatcher may pop
        longint      issue_cyc = -1;  // cycle carrying send_cmd_send
        bit          waiting   = 0;
        bit          armed     = 0;
        logic [24:0] m_addr    = '0;
        logic [15:0] m_cnt     = '0;
        bit          m_ovf     = 0;
        bit          m_to      = 0;

        always @(negedge clk) begin
            bit         tmo;
            logic [5:0] s;
            tmo = 0;
            if (armed) begin
                chk($sformatf("u%0d_send", g), send_o[g], (issue_cyc == mcyc));
                chk($sformatf("u%0d_addr", g), addr_o[g], m_addr);
                chk($sformatf("u%0d_level", g), lvl_o[g], q.size());
                chk($sformatf("u%0d_busy", g), busy_o[g], (mcyc < ready_at) || (q.size() != 0));
                chk($sformatf("u%0d_ovf", g), ovf_o[g], m_ovf);
                chk($sformatf("u%0d_tmo", g), to_o[g], m_to);
                chk($sformatf("u%0d_cnt", g), cnt_o[g], m_cnt);
            end
            if (rst) begin
                q.delete();
                ready_at  = mcyc + 1;
                issue_cyc = -1;
                waiting   = 0;
                m_addr    = '0;
                m_cnt     = '0;
                m_ovf     = 0;
                m_to      = 0;
                armed     = 1;
            end else begin
                if (waiting && mcyc > issue_cyc) begin
                    if (done) begin
                        m_cnt    = m_cnt + 16'd1;
                        waiting  = 0;
                        ready_at = mcyc + 1 + GEFF;
                    end else if (mcyc == issue_cyc + TMO) begin
                        tmo      = 1;
                        waiting  = 0;
                        ready_at = mcyc + 1 + GEFF;
                    end
                end
                if (mcyc >= ready_at && q.size() != 0) begin
                    s         = q.pop_front();
                    m_addr    = 25'((longint'(BASE) + (longint'(s) << 11)) % (longint'(1) << 25));
                    issue_cyc = mcyc + 1;
                    waiting   = 1;
                    ready_at  = longint'(1) << 40;
                end
                if (clr) begin
                    m_ovf = 0;
                    m_to  = 0;
                end
                if (sig) begin
                    if (q.size() < 4) q.push_back(slot);
                    else m_ovf = 1;
                end
                if (tmo) m_to = 1;
            end
            mcyc++;
        end
    end

    task automatic wait_send(input int g, input int max, output longint at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            if (send_o[g] === 1'b1) begin
                at = cyc;
                return;
            end
            step();
        end
        checks++;
        errors++;
        $display("FAIL wait_send_u%0d: no send_cmd_send within %0d cycles", g, max);
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            if (busy_o[0] === 1'b0 && busy_o[1] === 1'b0) return;
            step();
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: still busy after %0d cycles", max);
    endtask

    task automatic pulse_done();
        done = 1;
        step();
        done = 0;
    endtask

    task automatic pulse_clr();
        clr = 1;
        step();
        clr = 0;
    endtask

    initial begin
        longint at;
        longint prev;
        longint s0;
        int     pdone;
        rst = 1; sig = 0; done = 0; clr = 0; slot = '0;
        step();
        step();
        rst = 0;
        // reset state
        chk("rst_send", send_o[0], 0);
        chk("rst_addr", addr_o[0], 0);
        chk("rst_level", lvl_o[0], 0);
        chk("rst_ovf", ovf_o[0], 0);
        chk("rst_tmo", to_o[0], 0);
        chk("rst_cnt", cnt_o[0], 0);
        chk("rst_busy", busy_o[0], 0);

        // latency and address, slot 3
        sig = 1; slot = 6'd3;
        step(); sig = 0;
        chk("lat_n1_send", send_o[0], 0);
        step();
        chk("lat_n2_send", send_o[0], 1);
        chk("lat_addr", addr_o[0], 25'h1800);
        chk("lat_addr_b", addr_o[1], 25'h0000800);
        step();
        pulse_done();
        chk("first_cnt", cnt_o[0], 1);
        chk("first_cnt_b", cnt_o[1], 1);
        repeat (20) step();

        // stall in WAIT_DONE, 6 pushes, clear_flags on the last overflowing push
        wait_idle(60);
        sig = 1; slot = 6'd1;
        step(); sig = 0;
        step();
        for (int i = 0; i < 6; i++) begin
            step();
            sig = 1;
            slot = 6'(10 + i);
            clr = (i == 5);
        end
        step(); sig = 0; clr = 0;
        chk("stall_level", lvl_o[0], 4);
        chk("stall_ovf", ovf_o[0], 1);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            pulse_done();
            wait_send(0, 40, at);
            chk("order_addr", addr_o[0], 25'((10 + k) << 11));
            if (k > 0) chk("issue_spacing", (at - prev >= 12), 1);
            prev = at;
            step();
        end
        pulse_done();
        repeat (20) step();
        pulse_clr();
        chk("ovf_cleared", ovf_o[0], 0);

        // timeout, then the queued entry issues after the gap
        wait_idle(80);
        sig = 1; slot = 6'd5;
        step(); slot = 6'd6;
        step(); sig = 0;
        chk("tmo_send", send_o[0], 1);
        chk("tmo_addr", addr_o[0], 25'(5 << 11));
        s0 = cyc;
        repeat (100) step();
        chk("tmo_not_yet", to_o[0], 0);
        step();
        chk("tmo_set", to_o[0], 1);
        chk("tmo_cnt", cnt_o[0], 6);
        wait_send(0, 30, at);
        chk("tmo_next_issue", 32'(at - s0), 114);
        chk("tmo_next_addr", addr_o[0], 25'(6 << 11));
        step();
        pulse_done();
        chk("tmo_after_cnt", cnt_o[0], 7);
        pulse_clr();
        repeat (20) step();

        // base wrap on lane 1, and zero-length gap
        wait_idle(80);
        sig = 1; slot = 6'd63;
        step(); slot = 6'd7;
        step(); sig = 0;
        chk("wrap_send_b", send_o[1], 1);
        chk("wrap_addr_b", addr_o[1], 25'h001E800);
        chk("wrap_addr_a", addr_o[0], 25'h001F800);
        step();
        pulse_done();
        step();
        chk("gap0_idle_b", send_o[1], 0);
        step();
        chk("gap0_send_b", send_o[1], 1);
        chk("gap0_addr_b", addr_o[1], 25'h0002800);
        step();
        pulse_done();

        // reset during WAIT_DONE, then a stale tx_done
        wait_idle(200);
        pulse_clr();
        sig = 1; slot = 6'd2;
        step(); sig = 0;
        step();
        step();
        rst = 1;
        step(); rst = 0;
        chk("rwd_send", send_o[0], 0);
        chk("rwd_addr", addr_o[0], 0);
        chk("rwd_level", lvl_o[0], 0);
        chk("rwd_ovf", ovf_o[0], 0);
        chk("rwd_tmo", to_o[0], 0);
        chk("rwd_cnt", cnt_o[0], 0);
        chk("rwd_busy", busy_o[0], 0);
        pulse_done();
        chk("rwd_cnt_after", cnt_o[0], 0);
        chk("rwd_busy_after", busy_o[0], 0);
        chk("rwd_cnt_after_b", cnt_o[1], 0);

        // randomized traffic
        pdone = 1;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) pdone = ((i / 500) % 3 == 0) ? 1 : (((i / 500) % 3 == 1) ? 4 : 25);
            sig  = ($urandom_range(0, 99) < 35);
            slot = 6'($urandom);
            done = ($urandom_range(0, 99) < pdone);
            clr  = ($urandom_range(0, 99) < 3);
            rst  = ($urandom_range(0, 999) < 2);
            step();
        end
        sig = 0; done = 0; clr = 0; rst = 0;
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
